// File: rtl/muldiv_seq_if.sv
//------------------------------------------------------------------------------
// muldiv_seq_if
// Handshake/data bundle between the EX stage and the sequential RV32M unit.
//
// Signals:
//   start_EX       EX -> unit   RV32M instruction present in EX
//   FUNCT3_EX[2:0] EX -> unit   operation select (MUL..REMU)
//   OP_A_EX[31:0]  EX -> unit   forwarded rs1 value
//   OP_B_EX[31:0]  EX -> unit   forwarded rs2 value
//   flush_EX       EX -> unit   abort the current operation
//   stall_EX       unit -> EX   freeze IF/ID/EX while busy
//   done_EX        unit -> EX   one-cycle result-valid pulse
//   MULDIV_OUT_EX  unit -> EX   result, qualified by done_EX
//
// Modports: master = pipeline side, slave = muldiv_seq.
//------------------------------------------------------------------------------
interface muldiv_seq_if;
    logic        start_EX;
    logic [2:0]  FUNCT3_EX;
    logic [31:0] OP_A_EX;
    logic [31:0] OP_B_EX;
    logic        flush_EX;
    logic        stall_EX;
    logic        done_EX;
    logic [31:0] MULDIV_OUT_EX;

    modport master (
        output start_EX, FUNCT3_EX, OP_A_EX, OP_B_EX, flush_EX,
        input  stall_EX, done_EX, MULDIV_OUT_EX
    );

    modport slave (
        input  start_EX, FUNCT3_EX, OP_A_EX, OP_B_EX, flush_EX,
        output stall_EX, done_EX, MULDIV_OUT_EX
    );
endinterface

// File: rtl/muldiv_seq.sv
//------------------------------------------------------------------------------
// muldiv_seq
// Sequential RV32M multiply/divide unit for the EX stage. One bit per cycle:
// shift-add multiply on a 64-bit product, restoring divide on a 32-bit
// remainder/quotient pair. Operands are taken as magnitudes and the sign is
// applied to the final result.
//
// Timing: cycle 1 accepts (IDLE), cycles 2..33 compute (CALC), cycle 34
// presents the result (DONE, done_EX=1).
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    muldiv_seq_if.slave (start/funct3/operands/flush in,
//          stall/done/result out)
//
// Configuration:
//   MULDIV_EARLY_OUT_EN  when defined, divide by zero and multiply by zero
//                        skip CALC and finish in 2 cycles.
//------------------------------------------------------------------------------
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Latched operation context
    logic [2:0]  op_q;
    logic        neg_q;       // result must be negated
    logic [5:0]  cnt_q;
    // Multiply: 64-bit product / multiplier shift register.
    // Divide:   {remainder, quotient/dividend} shift register.
    logic [63:0] acc_q;
    logic [31:0] opb_q;       // multiplicand or divisor magnitude
    logic [31:0] out_q;

    // FSM strobes
    logic        accept;
    logic        early_hit;
    logic        step_en;
    logic        finish;
    logic        stall;
    logic        done;

    //--------------------------------------------------------------------------
    // Operand conditioning for a new operation
    //--------------------------------------------------------------------------
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_in;

    always_comb begin
        // MUL low word is sign-agnostic; treating it as signed keeps one path.
        unique case (bus.FUNCT3_EX)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
            default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
        endcase
        a_neg = a_signed & bus.OP_A_EX[31];
        b_neg = b_signed & bus.OP_B_EX[31];
        a_mag = a_neg ? -bus.OP_A_EX : bus.OP_A_EX;
        b_mag = b_neg ? -bus.OP_B_EX : bus.OP_B_EX;
        if (!bus.FUNCT3_EX[2])
            neg_in = a_neg ^ b_neg;
        else if (bus.FUNCT3_EX[1])
            neg_in = a_neg;                                // remainder follows dividend
        else
            neg_in = (a_neg ^ b_neg) & (bus.OP_B_EX != '0); // x/0 stays all-ones
    end

    //--------------------------------------------------------------------------
    // Optional early-out for trivially known results
    //--------------------------------------------------------------------------
    logic [31:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        if (bus.FUNCT3_EX[2]) begin
            early_hit = (bus.OP_B_EX == '0);
            early_res = bus.FUNCT3_EX[1] ? bus.OP_A_EX : 32'hFFFF_FFFF;
        end else begin
            early_hit = (bus.OP_A_EX == '0) || (bus.OP_B_EX == '0);
            early_res = '0;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_res = '0;
`endif

    //--------------------------------------------------------------------------
    // One iteration of the datapath and the final signed result
    //--------------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] step;
    logic [63:0] prod_signed;
    logic [31:0] div_raw;
    logic [31:0] final_res;

    always_comb begin
        // Shift-add: add multiplicand to the upper half when the multiplier
        // LSB is set, then shift the 65-bit {carry, product} right by one.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        // Restoring divide: trial-subtract divisor from {rem, next dividend bit}.
        // Bit 32 of the difference is the borrow (remainder < divisor).
        div_diff = {acc_q[63:32], acc_q[31]} - {1'b0, opb_q};

        if (!op_q[2])
            step = {mul_sum, acc_q[31:1]};
        else if (!div_diff[32])
            step = {div_diff[31:0], acc_q[30:0], 1'b1};
        else
            step = {acc_q[62:31], acc_q[30:0], 1'b0};

        prod_signed = neg_q ? -step : step;
        div_raw     = op_q[1] ? step[63:32] : step[31:0];

        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
        else
            final_res = neg_q ? -div_raw : div_raw;
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, checked inside the edge.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    //--------------------------------------------------------------------------
    // FSM: next state and outputs
    //--------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start_EX && !bus.flush_EX && !reset) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = early_hit ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (bus.flush_EX) begin
                    state_next = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == 6'd31) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            out_q <= '0;
        end else if (accept) begin
            op_q  <= bus.FUNCT3_EX;
            neg_q <= neg_in;
            cnt_q <= '0;
            if (bus.FUNCT3_EX[2]) begin
                acc_q <= {32'd0, a_mag};
                opb_q <= b_mag;
            end else begin
                acc_q <= {32'd0, b_mag};
                opb_q <= a_mag;
            end
            if (early_hit)
                out_q <= early_res;
        end else if (step_en) begin
            acc_q <= step;
            cnt_q <= cnt_q + 6'd1;
            if (finish)
                out_q <= final_res;
        end
    end

    assign bus.stall_EX      = stall;
    assign bus.done_EX       = done;
    assign bus.MULDIV_OUT_EX = out_q;

endmodule
